// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_pkg
// Description : Shared CPU typedefs and constants for the data cache.
//               FSM state encodings, RV32I load/store func3 encodings,
//               and byte-strobe base patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package data_cache_pkg;

    // Cache controller FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_DONE = 3'd4;

    typedef logic [2:0] func3_t;
    typedef logic [3:0] strb_t;

    // RV32I load encodings
    localparam func3_t F3_LB  = 3'b000;
    localparam func3_t F3_LH  = 3'b001;
    localparam func3_t F3_LW  = 3'b010;
    localparam func3_t F3_LBU = 3'b100;
    localparam func3_t F3_LHU = 3'b101;

    // RV32I store encodings
    localparam func3_t F3_SB  = 3'b000;
    localparam func3_t F3_SH  = 3'b001;
    localparam func3_t F3_SW  = 3'b010;

    // Strobe base patterns; byte/half are shifted into place by offset
    localparam strb_t STRB_NONE = 4'b0000;
    localparam strb_t STRB_BYTE = 4'b0001;
    localparam strb_t STRB_HALF = 4'b0011;
    localparam strb_t STRB_WORD = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_if
// Description : Backing-memory bus between the data cache and memory.
//               Request channel: valid/ready handshake with we, word-aligned
//               addr, lane-replicated wdata and byte strobes.
//               Response channel: one-cycle resp_valid with the read word.
//   master : cache side (drives requests, receives responses)
//   slave  : memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface data_cache_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_we;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [3:0]            mem_req_strb;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_we,
        output mem_req_addr,
        output mem_req_wdata,
        output mem_req_strb,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_we,
        input  mem_req_addr,
        input  mem_req_wdata,
        input  mem_req_strb,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Byte-lane steering for RV32I loads and stores. Shared by
//               the data cache and data_memory.
//   func3       in  : load/store width and sign
//   offset      in  : address[1:0]
//   rdata       in  : aligned memory word being loaded from
//   wdata       in  : right-aligned store data
//   load_data   out : selected and extended load result
//   store_wdata out : store data replicated across all lanes
//   store_strb  out : byte write strobes
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import data_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            func3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_wdata,
    output logic [3:0]            store_strb
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Load path: misaligned halfwords fall back to the aligned half chosen
    // by offset[1]; words ignore the offset entirely. Nothing traps.
    always_comb begin
        w_byte    = rdata[{offset, 3'b000} +: 8];
        w_half    = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (func3)
            F3_LB:   load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_LH:   load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: load_data = rdata;
        endcase
    end

    // Store path: data is replicated across every lane so the strobes alone
    // decide which bytes land; undefined encodings write nothing.
    always_comb begin
        store_strb  = STRB_NONE;
        store_wdata = wdata;
        case (func3)
            F3_SB: begin
                store_strb  = STRB_BYTE << offset;
                store_wdata = {(DATA_WIDTH/8){wdata[7:0]}};
            end
            F3_SH: begin
                store_strb  = STRB_HALF << {offset[1], 1'b0};
                store_wdata = {(DATA_WIDTH/16){wdata[15:0]}};
            end
            F3_SW: begin
                store_strb  = STRB_WORD;
                store_wdata = wdata;
            end
            default: begin
                store_strb  = STRB_NONE;
                store_wdata = wdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, one-word-per-line, write-through,
//               no-write-allocate data cache for the MEMORY stage.
//   clk, rst      : clock, asynchronous active-high reset
//   rd_en         : load request
//   write_enable  : store request (wins over a simultaneous load)
//   func3         : RV32I load/store width and sign
//   address       : byte address
//   write_data    : right-aligned store data
//   data_out      : extended load result, 0 unless a load hits in IDLE
//   stall         : pipeline freeze while the request is incomplete
//   mem           : backing-memory bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache
    import data_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  write_enable,
    input  logic [2:0]            func3,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  stall,
    data_cache_if.master          mem
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;

    // ------------------------------------------------------------------
    // Line storage: only the valid bits are reset; tag/data behave as RAM
    // ------------------------------------------------------------------
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] r_data_mem [LINES];

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;

    // Request latched on leaving IDLE so the memory bus stays stable
    // regardless of what the pipeline presents during the transaction.
    logic [DATA_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_wdata;
    logic [3:0]            r_req_strb;

    // Lookup of the currently presented address
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic [DATA_WIDTH-1:0] w_line_data;
    logic                  w_hit;

    // Lookup of the latched request address
    logic [INDEX_BITS-1:0] w_req_idx;
    logic [TAG_BITS-1:0]   w_req_tag;
    logic [DATA_WIDTH-1:0] w_req_line;
    logic                  w_req_hit;
    logic [DATA_WIDTH-1:0] w_merged;

    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_store_wdata;
    logic [3:0]            w_store_strb;

    logic                  w_in_idle;
    logic                  w_accept;
    logic                  w_fill;
    logic                  w_store_update;

    assign w_idx       = address[INDEX_BITS+1:2];
    assign w_tag       = address[DATA_WIDTH-1:INDEX_BITS+2];
    assign w_line_data = r_data_mem[w_idx];
    assign w_hit       = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);

    assign w_req_idx   = r_req_addr[INDEX_BITS+1:2];
    assign w_req_tag   = r_req_addr[DATA_WIDTH-1:INDEX_BITS+2];
    assign w_req_line  = r_data_mem[w_req_idx];
    assign w_req_hit   = r_valid[w_req_idx] && (r_tag_mem[w_req_idx] == w_req_tag);

    assign w_in_idle   = (r_state == ST_IDLE);
    // A store always leaves IDLE; a load leaves only when it misses.
    assign w_accept    = w_in_idle && (write_enable || (rd_en && !w_hit));
    // Responses outside RD_WAIT (including after an aborting reset) are dropped.
    assign w_fill      = (r_state == ST_RD_WAIT) && mem.mem_resp_valid;
    // Write-through: the line is only patched if the store hits.
    assign w_store_update = (r_state == ST_WR_REQ) && mem.mem_req_ready && w_req_hit;

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_align (
        .func3       (func3),
        .offset      (address[1:0]),
        .rdata       (w_line_data),
        .wdata       (write_data),
        .load_data   (w_load_data),
        .store_wdata (w_store_wdata),
        .store_strb  (w_store_strb)
    );

    // Strobed byte merge of the latched store into the hit line
    always_comb begin
        w_merged = w_req_line;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (r_req_strb[b]) begin
                w_merged[8*b +: 8] = r_req_wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (write_enable) begin
                    w_next_state = ST_WR_REQ;
                end else if (rd_en && !w_hit) begin
                    w_next_state = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (mem.mem_req_ready) begin
                    w_next_state = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem.mem_resp_valid) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (mem.mem_req_ready) begin
                    w_next_state = ST_WR_DONE;
                end
            end
            ST_WR_DONE: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        stall    = 1'b0;
        data_out = '0;
        case (r_state)
            ST_IDLE: begin
                stall = write_enable || (rd_en && !w_hit);
                if (rd_en && !write_enable && w_hit) begin
                    data_out = w_load_data;
                end
            end
            ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ: stall = 1'b1;
            // WR_DONE lets the store retire; requests there are ignored.
            default: stall = 1'b0;
        endcase
    end

    assign mem.mem_req_valid = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
    assign mem.mem_req_we    = (r_state == ST_WR_REQ);
    assign mem.mem_req_addr  = r_req_addr;
    assign mem.mem_req_wdata = r_req_wdata;
    assign mem.mem_req_strb  = (r_state == ST_WR_REQ) ? r_req_strb : STRB_NONE;

    // ------------------------------------------------------------------
    // State, request latch and valid bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_valid     <= '0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_strb  <= STRB_NONE;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_req_addr  <= {address[DATA_WIDTH-1:2], 2'b00};
                r_req_wdata <= w_store_wdata;
                r_req_strb  <= write_enable ? w_store_strb : STRB_NONE;
            end
            if (w_fill) begin
                r_valid[w_req_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays: refill on read response, byte patch on store hit
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag_mem[w_req_idx]  <= w_req_tag;
            r_data_mem[w_req_idx] <= mem.mem_resp_data;
        end else if (w_store_update) begin
            r_data_mem[w_req_idx] <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache
// Description : Scoreboard bench for data_cache. Stimulus tasks push the
//               expected load results and memory requests into queues; a
//               monitor pops and compares whenever a load completes or a
//               memory handshake occurs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;
    import data_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        write_enable = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] data_out;
    logic        stall;

    data_cache_if #(.DATA_WIDTH(32)) mem_bus ();

    data_cache #(
        .DATA_WIDTH (32),
        .INDEX_BITS (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .write_enable (write_enable),
        .func3        (func3),
        .address      (address),
        .write_data   (write_data),
        .data_out     (data_out),
        .stall        (stall),
        .mem          (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    logic [31:0] load_q[$];
    req_t        req_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mon_load;
    req_t        mon_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en && !write_enable && !stall) begin
                if (load_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_load: data_out %h, none expected", data_out);
                end else begin
                    mon_load = load_q.pop_front();
                    check("load_data", data_out, mon_load);
                end
            end
            if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
                if (req_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_req: addr %h we %b, none expected",
                             mem_bus.mem_req_addr, mem_bus.mem_req_we);
                end else begin
                    mon_req = req_q.pop_front();
                    check("req_we",   {31'd0, mem_bus.mem_req_we}, {31'd0, mon_req.we});
                    check("req_addr", mem_bus.mem_req_addr, mon_req.addr);
                    check("req_strb", {28'd0, mem_bus.mem_req_strb}, {28'd0, mon_req.strb});
                    if (mon_req.we) begin
                        check("req_wdata", mem_bus.mem_req_wdata, mon_req.wdata);
                    end
                end
            end
        end
    end

    // Entered just after the edge starting a request state. Holds ready low
    // for rdly cycles checking bus stability, then completes the handshake.
    task automatic hold_ready(input int rdly);
        logic [31:0] a0, w0;
        logic [3:0]  s0;
        logic        we0;
        if (rdly > 0) begin
            @(negedge clk);
            check("req_valid", {31'd0, mem_bus.mem_req_valid}, 32'd1);
            check("req_stall", {31'd0, stall}, 32'd1);
            a0 = mem_bus.mem_req_addr;  w0 = mem_bus.mem_req_wdata;
            s0 = mem_bus.mem_req_strb;  we0 = mem_bus.mem_req_we;
            for (int i = 1; i < rdly; i++) begin
                tick();
                @(negedge clk);
                check("hold_valid", {31'd0, mem_bus.mem_req_valid}, 32'd1);
                check("hold_addr",  mem_bus.mem_req_addr, a0);
                check("hold_wdata", mem_bus.mem_req_wdata, w0);
                check("hold_strb",  {28'd0, mem_bus.mem_req_strb}, {28'd0, s0});
                check("hold_we",    {31'd0, mem_bus.mem_req_we}, {31'd0, we0});
                check("hold_stall", {31'd0, stall}, 32'd1);
            end
            tick();
        end
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        check("hs_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_bus.mem_req_ready = 1'b0;
    endtask

    task automatic load_hit(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp);
        rd_en = 1'b1; address = a; func3 = f3;
        load_q.push_back(exp);
        @(negedge clk);
        check("hit_stall",  {31'd0, stall}, 32'd0);
        check("hit_no_req", {31'd0, mem_bus.mem_req_valid}, 32'd0);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic load_miss(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] word,
                             input logic [31:0] exp, input int rdly, input int respdly);
        req_t r;
        rd_en = 1'b1; address = a; func3 = f3;
        r.we = 1'b0; r.addr = {a[31:2], 2'b00}; r.strb = 4'b0000; r.wdata = '0;
        req_q.push_back(r);
        load_q.push_back(exp);
        @(negedge clk);
        check("miss_stall",  {31'd0, stall}, 32'd1);
        check("miss_dout",   data_out, 32'd0);
        check("miss_no_req", {31'd0, mem_bus.mem_req_valid}, 32'd0);
        tick();
        hold_ready(rdly);
        for (int i = 1; i < respdly; i++) begin
            @(negedge clk);
            check("wait_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data  = word;
        @(negedge clk);
        check("resp_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        check("fill_stall", {31'd0, stall}, 32'd0);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                         input logic also_rd, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata, input int rdly);
        req_t r;
        write_enable = 1'b1; rd_en = also_rd; address = a; func3 = f3; write_data = wd;
        r.we = 1'b1; r.addr = {a[31:2], 2'b00}; r.strb = exp_strb; r.wdata = exp_wdata;
        req_q.push_back(r);
        @(negedge clk);
        check("st_stall", {31'd0, stall}, 32'd1);
        check("st_dout",  data_out, 32'd0);
        tick();
        hold_ready(rdly);
        @(negedge clk);
        check("wd_stall",  {31'd0, stall}, 32'd0);
        check("wd_no_req", {31'd0, mem_bus.mem_req_valid}, 32'd0);
        check("wd_dout",   data_out, 32'd0);
        tick();
        write_enable = 1'b0; rd_en = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_data  = '0;

        // Reset state
        #2;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_valid", {31'd0, mem_bus.mem_req_valid}, 32'd0);
        check("rst_we",    {31'd0, mem_bus.mem_req_we}, 32'd0);
        check("rst_strb",  {28'd0, mem_bus.mem_req_strb}, 32'd0);
        check("rst_dout",  data_out, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Cold miss with 3-cycle response latency, then hit
        load_miss(32'h100, F3_LW, 32'hDEADBEEF, 32'hDEADBEEF, 1, 3);
        load_hit (32'h100, F3_LW,  32'hDEADBEEF);

        // Lane select and extension
        load_hit(32'h103, F3_LB,  32'hFFFFFFDE);
        load_hit(32'h103, F3_LBU, 32'h000000DE);
        load_hit(32'h102, F3_LH,  32'hFFFFDEAD);
        load_hit(32'h100, F3_LHU, 32'h0000BEEF);
        load_hit(32'h100, F3_LB,  32'hFFFFFFEF);
        load_hit(32'h101, F3_LH,  32'hFFFFBEEF);  // misaligned: aligned low half
        load_hit(32'h102, F3_LW,  32'hDEADBEEF);  // offset ignored

        // Store hits patch only strobed bytes
        store(32'h101, F3_SB, 32'h00000055, 1'b0, 4'b0010, 32'h55555555, 0);
        load_hit(32'h100, F3_LW, 32'hDEAD55EF);
        store(32'h102, F3_SH, 32'h00001234, 1'b0, 4'b1100, 32'h12341234, 1);
        load_hit(32'h102, F3_LHU, 32'h00001234);
        load_hit(32'h100, F3_LH,  32'h000055EF);

        // Store miss does not allocate
        store(32'h104, F3_SW, 32'hCAFEBABE, 1'b0, 4'b1111, 32'hCAFEBABE, 0);
        load_miss(32'h104, F3_LW, 32'h11112222, 32'h11112222, 0, 1);

        // Store wins over a simultaneous load
        store(32'h104, F3_SW, 32'hA5A5A5A5, 1'b1, 4'b1111, 32'hA5A5A5A5, 2);
        load_hit(32'h104, F3_LW, 32'hA5A5A5A5);

        // Ready held low for 5 cycles; conflicting tag replaces the line
        load_miss(32'h200, F3_LW, 32'h0BADF00D, 32'h0BADF00D, 5, 2);
        load_hit (32'h200, F3_LBU, 32'h0000000D);
        load_miss(32'h100, F3_LW, 32'h123455EF, 32'h123455EF, 0, 1);

        // Reset during RD_WAIT aborts; a late response is ignored
        begin
            req_t r;
            rd_en = 1'b1; address = 32'h180; func3 = F3_LW;
            r.we = 1'b0; r.addr = 32'h180; r.strb = 4'b0000; r.wdata = '0;
            req_q.push_back(r);
            @(negedge clk);
            check("ab_miss_stall", {31'd0, stall}, 32'd1);
            tick();
            mem_bus.mem_req_ready = 1'b1;
            @(negedge clk);
            tick();
            mem_bus.mem_req_ready = 1'b0;
            @(negedge clk);
            check("ab_wait_stall", {31'd0, stall}, 32'd1);
            #2;
            rst = 1'b1;
            rd_en = 1'b0;
            #1;
            check("ab_rst_stall", {31'd0, stall}, 32'd0);
            check("ab_rst_valid", {31'd0, mem_bus.mem_req_valid}, 32'd0);
            tick();
            tick();
            rst = 1'b0;
            mem_bus.mem_resp_valid = 1'b1;
            mem_bus.mem_resp_data  = 32'h99999999;
            @(negedge clk);
            check("late_stall", {31'd0, stall}, 32'd0);
            check("late_valid", {31'd0, mem_bus.mem_req_valid}, 32'd0);
            tick();
            mem_bus.mem_resp_valid = 1'b0;
            @(negedge clk);
            check("post_stall", {31'd0, stall}, 32'd0);
            tick();
        end
        load_miss(32'h100, F3_LW, 32'h123455EF, 32'h123455EF, 0, 1);
        load_miss(32'h180, F3_LW, 32'h77778888, 32'h77778888, 1, 2);

        repeat (3) tick();
        check("load_q_drained", load_q.size(), 32'd0);
        check("req_q_drained",  req_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares",
                 vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
